// File: rtl/pifo_reg_hs.sv
// Register-based PIFO with valid/ready handshakes on both sides: holds up to DEPTH
// (rank, meta) entries in arrival order, presents the minimum rank and drops on overflow.
module pifo_reg_hs #(
  parameter int DEPTH       = 8,
  parameter int RANK_WIDTH  = 16,
  parameter int META_WIDTH  = 32,
  parameter int DROP_POLICY = 1,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [RANK_WIDTH-1:0] ins_rank,
  input  logic [META_WIDTH-1:0] ins_meta,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [RANK_WIDTH-1:0] deq_rank,
  output logic [META_WIDTH-1:0] deq_meta,
  output logic                  drop_valid,
  output logic [RANK_WIDTH-1:0] drop_rank,
  output logic [META_WIDTH-1:0] drop_meta,
  output logic [31:0]           drop_count,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic {READY, SETTLE} state_t;
  state_t state_q;

  logic [RANK_WIDTH-1:0] rank_q   [DEPTH];
  logic [META_WIDTH-1:0] meta_q   [DEPTH];
  logic [RANK_WIDTH-1:0] rank_nxt [DEPTH];
  logic [META_WIDTH-1:0] meta_nxt [DEPTH];

  logic [IW-1:0]         min_idx, max_idx;
  logic [RANK_WIDTH-1:0] min_rank, max_rank;
  logic [META_WIDTH-1:0] min_meta, max_meta;
  logic                  min_found, max_found;

  logic                  ins_fire, deq_fire;
  logic                  remove_en, append_en, drop_en;
  logic [IW-1:0]         remove_idx;
  logic [CW-1:0]         append_idx, count_nxt;
  logic [RANK_WIDTH-1:0] drop_rank_nxt;
  logic [META_WIDTH-1:0] drop_meta_nxt;

  // Slot occupancy is implied by compaction: slot i is live iff i < count.
  // Strict < keeps the oldest on min ties; >= moves to the newest on max ties.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    min_idx   = '0;
    max_idx   = '0;
    min_rank  = '0;
    max_rank  = '0;
    min_meta  = '0;
    max_meta  = '0;
    min_found = 1'b0;
    max_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count) begin
        if (!min_found || rank_q[i] < min_rank) begin
          min_found = 1'b1;
          min_idx   = IW'(i);
          min_rank  = rank_q[i];
          min_meta  = meta_q[i];
        end
        if (!max_found || rank_q[i] >= max_rank) begin
          max_found = 1'b1;
          max_idx   = IW'(i);
          max_rank  = rank_q[i];
          max_meta  = meta_q[i];
        end
      end
    end
  end

  assign ins_ready = (state_q == READY) && ((DROP_POLICY == 1) || !full);
  assign deq_valid = (state_q == READY) && !empty;
  assign ins_fire  = ins_valid && ins_ready;
  assign deq_fire  = deq_valid && deq_ready;

  // A dequeue takes priority over overflow handling: insert+dequeue never drops.
  always_comb begin
    remove_en     = 1'b0;
    remove_idx    = '0;
    append_en     = 1'b0;
    drop_en       = 1'b0;
    drop_rank_nxt = '0;
    drop_meta_nxt = '0;
    if (deq_fire) begin
      remove_en  = 1'b1;
      remove_idx = min_idx;
      append_en  = ins_fire;
    end else if (ins_fire) begin
      if (!full) begin
        append_en = 1'b1;
      end else if (ins_rank < max_rank) begin
        remove_en     = 1'b1;
        remove_idx    = max_idx;
        append_en     = 1'b1;
        drop_en       = 1'b1;
        drop_rank_nxt = max_rank;
        drop_meta_nxt = max_meta;
      end else begin
        drop_en       = 1'b1;
        drop_rank_nxt = ins_rank;
        drop_meta_nxt = ins_meta;
      end
    end
    append_idx = count - CW'(remove_en);
    count_nxt  = count + CW'(append_en) - CW'(remove_en);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rank_nxt[i] = rank_q[i];
      meta_nxt[i] = meta_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (remove_en && IW'(i) >= remove_idx) begin
        rank_nxt[i] = rank_q[i + 1];
        meta_nxt[i] = meta_q[i + 1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (append_en && CW'(i) == append_idx) begin
        rank_nxt[i] = ins_rank;
        meta_nxt[i] = ins_meta;
      end
    end
  end

  // NOTE: slot contents are not reset; clearing count invalidates every slot.
  always_ff @(posedge clk) begin
    if (state_q == READY) begin
      rank_q <= rank_nxt;
      meta_q <= meta_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= READY;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      deq_rank   <= '0;
      deq_meta   <= '0;
      drop_valid <= 1'b0;
      drop_rank  <= '0;
      drop_meta  <= '0;
      drop_count <= '0;
    end else begin
      drop_valid <= 1'b0;
      case (state_q)
        READY: begin
          if (ins_fire || deq_fire) begin
            state_q <= SETTLE;
            count   <= count_nxt;
            empty   <= (count_nxt == '0);
            full    <= (count_nxt == CW'(DEPTH));
          end
          if (drop_en) begin
            drop_valid <= 1'b1;
            drop_rank  <= drop_rank_nxt;
            drop_meta  <= drop_meta_nxt;
            if (drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
          end
        end
        SETTLE: begin
          state_q  <= READY;
          deq_rank <= min_rank;
          deq_meta <= min_meta;
        end
        default: state_q <= READY;
      endcase
    end
  end

endmodule

// File: doc/pifo_reg_hs.md
Name: pifo_reg_hs

Overview:
- Parametrised successor to the small register-based PIFO used in the scheduler datapath. Stores up to DEPTH (rank, meta) entries and always presents the minimum-rank entry for dequeue.
- Adds valid/ready handshakes on both sides, arbitrary (non power-of-two) depth, and deterministic FIFO tie-breaking.
- Adds a selectable overflow policy with an explicit drop/evict output port and a saturating drop counter.
- Sits between the rank computation stage and the output-queue arbiter.

Parameters:
- DEPTH, 8, number of entry slots; legal range 2..64.
- RANK_WIDTH, 16, rank bits; unsigned, smaller rank = higher priority.
- META_WIDTH, 32, opaque metadata bits carried with each entry.
- DROP_POLICY, 1: 0 = reject inserts when full; 1 = accept, keep the DEPTH smallest ranks, emit the loser on the drop port.
- Local CW = clog2(DEPTH+1) (count width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted when ins_valid && ins_ready
- ins_rank  in  RANK_WIDTH  rank of new entry
- ins_meta  in  META_WIDTH  meta of new entry
- deq_valid  out  1  head entry available
- deq_ready  in  1  consumer takes head when deq_valid && deq_ready
- deq_rank  out  RANK_WIDTH  rank of current minimum (registered)
- deq_meta  out  META_WIDTH  meta of current minimum (registered)
- drop_valid  out  1  one-cycle pulse: an entry was discarded
- drop_rank  out  RANK_WIDTH  rank of discarded entry
- drop_meta  out  META_WIDTH  meta of discarded entry
- drop_count  out  32  saturating count of discarded entries
- count  out  CW  occupied slots
- empty  out  1  count == 0
- full  out  1  count == DEPTH

Behaviour:
- Storage:
  - Slots 0..count-1 are always compacted, in arrival order (lower index = older).
  - Removing a slot shifts all higher slots down by one.
  - A new entry is written at index count after any removal in the same cycle.
- Selection (combinational over occupied slots):
  - min = lowest rank; ties go to the lowest index (oldest).
  - max = highest rank; ties go to the highest index (newest).
- FSM states READY and SETTLE:
  - Any accepted transfer (insert, dequeue, or both) moves READY->SETTLE.
  - SETTLE->READY unconditionally after 1 cycle; in SETTLE, deq_rank/deq_meta are loaded from the min tree.
  - In SETTLE: ins_ready = 0 and deq_valid = 0. Peak throughput is one operation per 2 cycles.
- ready/valid in READY:
  - deq_valid = (count > 0).
  - ins_ready = (DROP_POLICY == 1) || !full.
  - ins_ready must not depend combinationally on deq_ready or ins_valid.
- Simultaneous insert + dequeue in the same cycle:
  - Head is removed, new entry appended, count unchanged.
  - Never a drop, even when full.
- Full, DROP_POLICY = 1, insert only:
  - If ins_rank < max rank: the max slot is removed (compacted) and the new entry appended. The evicted entry appears on drop_*.
  - Otherwise storage is unchanged and the incoming entry appears on drop_*.
  - Equal rank counts as "not smaller" and drops the incoming entry.
- drop_* timing:
  - drop_valid pulses for exactly 1 cycle, the cycle after acceptance; drop_rank/drop_meta are valid with it.
  - drop_count increments on each pulse and saturates at 0xFFFFFFFF.
- count/empty/full are registered and update the cycle after acceptance. Underflow is impossible because deq_valid gates removal.
- Reset:
  - count = 0, empty = 1, full = 0, state = READY.
  - deq_valid = 0, deq_rank = 0, deq_meta = 0.
  - drop_valid = 0, drop_rank = 0, drop_meta = 0, drop_count = 0.
  - ins_ready = 1 after reset.
  - All slot valid bits are cleared. Reset mid-SETTLE or mid-drop aborts the operation with no drop pulse.
- Non-power-of-two DEPTH: the min/max trees pad unused leaves as invalid; padded leaves never win.

Test Plan:
- DEPTH=4, insert ranks 7,3,9,3 (meta A,B,C,D) -> count=4, full=1; dequeues yield (3,B),(3,D),(7,A),(9,C); empty=1 after the last.
- DROP_POLICY=1, full with 7,3,9,3; insert (5,E) -> drop_valid pulse with (9,C), count stays 4, next deq=(3,B); then insert (9,F) -> drop (9,F), drop_count=2.
- DROP_POLICY=0, full; hold ins_valid -> ins_ready=0, storage unchanged, no drop pulse; one dequeue -> ins_ready returns to 1 after SETTLE.
- Full, ins_valid and deq_ready in the same READY cycle with insert (1,G) -> head removed, G stored, count=4, no drop; next deq=(1,G).
- Back-to-back ops -> every accept followed by exactly 1 SETTLE cycle with ins_ready=0 and deq_valid=0; assert rst during SETTLE -> all outputs at reset values the next cycle.
- DEPTH=5 (non power of two): fill with 5,4,3,2,1 -> deq order 1..5; drop_count saturation forced via bench preload -> stays 0xFFFFFFFF.
